// File: rtl/alu_op_encoder.sv
// RV32I decode stage: instruction -> ALU operation, immediate and SrcB select.
// One output register plus a skid entry so a stalled execute stage loses nothing.
module alu_op_encoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] out_operation,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic                     out_alu_src,
    output logic                     out_illegal
);

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]    imm;
        logic                     alu_src;
        logic                     illegal;
    } entry_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND  = 4'b0000;
    localparam logic [OPCODE_LENGTH-1:0] OP_OR   = 4'b0001;
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = 4'b0010;
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = 4'b0011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = 4'b0100;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = 4'b0101;
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = 4'b0110;
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = 4'b0111;
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = 4'b1000;
    localparam logic [OPCODE_LENGTH-1:0] OP_LUI  = 4'b1001;
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = 4'b1010;
    localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = 4'b1011;
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = 4'b1100;
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = 4'b1101;
    localparam logic [OPCODE_LENGTH-1:0] OP_JAL  = 4'b1110;
    localparam logic [OPCODE_LENGTH-1:0] OP_JALR = 4'b1111;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    entry_t dec;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u = {12'b0, in_instr[31:12]};

    always_comb begin
        dec = '0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dec.op = OP_ADD;
                        3'b111:  dec.op = OP_AND;
                        3'b110:  dec.op = OP_OR;
                        3'b100:  dec.op = OP_XOR;
                        3'b001:  dec.op = OP_SLL;
                        3'b101:  dec.op = OP_SRL;
                        3'b010:  dec.op = OP_SLT;
                        default: dec.illegal = 1'b1;
                    endcase
                end else if (f7 == 7'h20) begin
                    case (f3)
                        3'b000:  dec.op = OP_SUB;
                        3'b101:  dec.op = OP_SRA;
                        default: dec.illegal = 1'b1;
                    endcase
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec.alu_src = 1'b1;
                dec.imm     = imm_i;
                case (f3)
                    3'b000: dec.op = OP_ADD;
                    3'b111: dec.op = OP_AND;
                    3'b110: dec.op = OP_OR;
                    3'b100: dec.op = OP_XOR;
                    3'b010: dec.op = OP_SLT;
                    3'b001: begin
                        dec.op      = OP_SLL;
                        dec.illegal = (f7 != 7'h00);
                    end
                    3'b101: begin
                        dec.op      = (f7 == 7'h20) ? OP_SRA : OP_SRL;
                        dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec.op      = OP_ADD;
                dec.alu_src = 1'b1;
                dec.imm     = imm_i;
                dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                dec.op      = OP_ADD;
                dec.alu_src = 1'b1;
                dec.imm     = imm_s;
                dec.illegal = (f3 > 3'b010);
            end
            7'b1100011: begin
                dec.imm = imm_b;
                case (f3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    default: dec.illegal = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec.op      = OP_LUI;
                dec.alu_src = 1'b1;
                dec.imm     = imm_u;
            end
            7'b1101111: begin
                dec.op  = OP_JAL;
                dec.imm = imm_j;
            end
            7'b1100111: begin
                dec.op      = OP_JALR;
                dec.imm     = imm_i;
                dec.illegal = (f3 != 3'b000);
            end
            default: dec.illegal = 1'b1;
        endcase
        // An undecodable word still travels as a beat, with a zeroed payload
        if (dec.illegal) begin
            dec.op      = '0;
            dec.imm     = '0;
            dec.alu_src = 1'b0;
        end
    end

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   accept;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_d       = dec;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid     = main_valid_q;
    assign out_operation = main_q.op;
    assign out_imm       = main_q.imm;
    assign out_alu_src   = main_q.alu_src;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: decode table, scoreboard, stall/skid, reset and flush.
module tb_alu_op_encoder;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        src;
        logic        ill;
        logic        chk_imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, out_imm;
    logic [3:0]  out_operation;
    logic        out_alu_src, out_illegal;

    int   checks   = 0;
    int   failures = 0;
    vec_t q[$];
    vec_t cur_exp;
    vec_t tbl[16];
    logic rand_rdy = 1'b0;
    logic stalled  = 1'b0;
    logic [37:0] held;

    always #5 clk = ~clk;

    alu_op_encoder dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operation(out_operation), .out_imm(out_imm),
        .out_alu_src(out_alu_src), .out_illegal(out_illegal)
    );

    function automatic vec_t mk(logic [31:0] i, logic [3:0] o, logic [31:0] m,
                                logic s, logic il, logic ci);
        vec_t v;
        v.instr = i; v.op = o; v.imm = m; v.src = s; v.ill = il; v.chk_imm = ci;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (reset || flush) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                checks++;
                if ({out_operation, out_imm, out_alu_src, out_illegal} !== held) begin
                    failures++;
                    $display("FAIL hold got=%h exp=%h",
                             {out_operation, out_imm, out_alu_src, out_illegal}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_empty got_op=%h got_imm=%h exp=none",
                             out_operation, out_imm);
                end else begin
                    vec_t e;
                    e = q.pop_front();
                    if (out_operation !== e.op || out_alu_src !== e.src ||
                        out_illegal !== e.ill || (e.chk_imm && out_imm !== e.imm)) begin
                        failures++;
                        $display("FAIL beat instr=%h got=%h/%h/%b/%b exp=%h/%h/%b/%b",
                                 e.instr, out_operation, out_imm, out_alu_src,
                                 out_illegal, e.op, e.imm, e.src, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
            stalled = out_valid && !out_ready;
            held    = {out_operation, out_imm, out_alu_src, out_illegal};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(vec_t v);
        logic ok;
        in_valid = 1'b1;
        in_instr = v.instr;
        cur_exp  = v;
        for (int n = 0; n < 50; n++) begin
            ok = in_ready;
            step();
            if (ok) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (q.size() == 0 && !out_valid) break;
            step();
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(32'h002081B3, 4'b0010, 32'h0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(32'h402081B3, 4'b0011, 32'h0, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(32'hFFF00093, 4'b0010, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(32'h123452B7, 4'b1001, 32'h00012345, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(32'h00209463, 4'b1010, 32'h00000008, 1'b0, 1'b0, 1'b1);
        tbl[5]  = mk(32'h00000000, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        tbl[6]  = mk(32'h0020A223, 4'b0010, 32'h00000004, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(32'hFFC0A103, 4'b0010, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(32'h4020D093, 4'b0111, 32'h00000402, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(32'h008000EF, 4'b1110, 32'h00000008, 1'b0, 1'b0, 1'b1);
        tbl[10] = mk(32'h000080E7, 4'b1111, 32'h00000000, 1'b0, 1'b0, 1'b1);
        tbl[11] = mk(32'h0020B1B3, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        tbl[12] = mk(32'h00001097, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
        tbl[13] = mk(32'h0020A1B3, 4'b1100, 32'h0, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(32'hFE20CEE3, 4'b1011, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
        tbl[15] = mk(32'h00208063, 4'b1000, 32'h00000000, 1'b0, 1'b0, 1'b1);

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; cur_exp = tbl[0];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_op", {28'd0, out_operation}, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_src_ill", {30'd0, out_alu_src, out_illegal}, 32'd0);
        reset = 1'b0;
        step();

        // Back-to-back ADD/SUB with execute always ready
        out_ready = 1'b1;
        send(tbl[0]);
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        send(tbl[1]);
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        drain();

        // Full table with random backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 16; i++) send(tbl[i]);
        drain();

        // Stall: A held, B in skid, C waits
        out_ready = 1'b0;
        send(tbl[2]);
        send(tbl[3]);
        in_instr = tbl[4].instr;
        cur_exp  = tbl[4];
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        step();
        step();
        chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);
        chk("stall_op_a", {28'd0, out_operation}, 32'h2);
        chk("stall_imm_a", out_imm, 32'hFFFFFFFF);
        out_ready = 1'b1;
        send(tbl[4]);
        drain();

        // Reset asserted with the skid full acts without a clock edge
        out_ready = 1'b0;
        send(tbl[6]);
        send(tbl[7]);
        in_valid = 1'b0;
        chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        step();

        // Flush with skid full; the instruction offered that cycle vanishes
        send(tbl[8]);
        send(tbl[9]);
        in_valid = 1'b1;
        in_instr = tbl[10].instr;
        cur_exp  = tbl[10];
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (5) step();
        chk("flush_quiet", {31'd0, out_valid}, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
